rr_arbiter8: RTL and testbench

Round-robin arbiter sharing one resource among eight requesters, with bounded grant tenure and a 7-segment readout of the current owner. It sits above the 8-to-3 priority-encoder path. It turns a raw request vector into a fair, registered one-hot grant plus a 3-bit owner index. The index drives the board display and downstream muxing.

---
 rtl/rr_arbiter8.sv | 98 +++++++++
 tb/tb_rr_arbiter8.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter8 : 8-way round-robin arbiter, bounded tenure, 7-seg owner readout
// Revision    : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       vx,
  output logic [6:0] seg0
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] last_id;
  logic [7:0] hold_cnt;

  logic       sel_found;
  logic [2:0] sel_id;
  logic [2:0] scan_id;
  logic       release_now;
  logic       take;

  function automatic logic [6:0] seg_encode(input logic [2:0] id);
    case (id)
      3'd0:    seg_encode = 7'b1000000;
      3'd1:    seg_encode = 7'b1111001;
      3'd2:    seg_encode = 7'b0100100;
      3'd3:    seg_encode = 7'b0110000;
      3'd4:    seg_encode = 7'b0011001;
      3'd5:    seg_encode = 7'b0010010;
      3'd6:    seg_encode = 7'b0000010;
      default: seg_encode = 7'b1111000;
    endcase
  endfunction

  // Scan upward from the slot after the last winner; the last winner is
  // reached only at the end, so a sole expiring owner gets re-granted.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = 3'd0;
    scan_id   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_id = last_id + 3'(i) + 3'd1;
      if (!sel_found && req[scan_id]) begin
        sel_found = 1'b1;
        sel_id    = scan_id;
      end
    end
  end

  assign release_now = !req[gnt_id] || (hold_cnt == HOLD_LAST) || !en;
  assign take        = en && sel_found && ((state == IDLE) || release_now);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 8'd0;
      gnt_id   <= 3'd0;
      vx       <= 1'b0;
      seg0     <= SEG_BLANK;
      hold_cnt <= 8'd0;
      last_id  <= 3'd7;
    end else if (take) begin
      state    <= GRANT;
      gnt      <= 8'd1 << sel_id;
      gnt_id   <= sel_id;
      vx       <= 1'b1;
      seg0     <= seg_encode(sel_id);
      hold_cnt <= 8'd0;
      last_id  <= sel_id;
    end else if (state == GRANT && !release_now) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      state    <= IDLE;
      gnt      <= 8'd0;
      gnt_id   <= 3'd0;
      vx       <= 1'b0;
      seg0     <= SEG_BLANK;
      hold_cnt <= 8'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_arbiter8 : self-checking bench, three arbiters with MAX_HOLD 8/4/1
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;

  logic [7:0] gnt_w [3];
  logic [2:0] id_w  [3];
  logic       vx_w  [3];
  logic [6:0] seg_w [3];

  int total = 0;
  int bad   = 0;

  int mh      [3] = '{8, 4, 1};
  int m_owner [3];
  int m_ten   [3];
  int m_last  [3];

  logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] q;
    logic [7:0] g;
    logic [2:0] id;
    logic [6:0] s;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(8)) u_mh8 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_w[0]), .gnt_id(id_w[0]), .vx(vx_w[0]), .seg0(seg_w[0])
  );
  rr_arbiter8 #(.MAX_HOLD(4)) u_mh4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_w[1]), .gnt_id(id_w[1]), .vx(vx_w[1]), .seg0(seg_w[1])
  );
  rr_arbiter8 #(.MAX_HOLD(1)) u_mh1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt_w[2]), .gnt_id(id_w[2]), .vx(vx_w[2]), .seg0(seg_w[2])
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  // Reference: owner -1 means nobody; m_ten counts cycles already held.
  task automatic model_step(input logic r, input logic e, input logic [7:0] q);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_owner[i] = -1;
        m_ten[i]   = 0;
        m_last[i]  = 7;
      end else if (m_owner[i] >= 0 && q[m_owner[i]] && e && m_ten[i] < mh[i]) begin
        m_ten[i] = m_ten[i] + 1;
      end else if (e && q != 8'd0) begin
        m_owner[i] = pick(q, m_last[i]);
        m_last[i]  = m_owner[i];
        m_ten[i]   = 1;
      end else begin
        m_owner[i] = -1;
        m_ten[i]   = 0;
      end
    end
  endtask

  task automatic check_model();
    int eg;
    int eid;
    for (int i = 0; i < 3; i++) begin
      eg  = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
      eid = (m_owner[i] >= 0) ? m_owner[i] : 0;
      check($sformatf("model_gnt_mh%0d", mh[i]), int'(gnt_w[i]), eg);
      check($sformatf("model_id_mh%0d", mh[i]), int'(id_w[i]), eid);
      check($sformatf("model_vx_mh%0d", mh[i]), int'(vx_w[i]), int'(m_owner[i] >= 0));
      check($sformatf("model_seg_mh%0d", mh[i]), int'(seg_w[i]),
            (m_owner[i] >= 0) ? int'(seg_tab[eid]) : 7'h7F);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [7:0] q);
    rst = r;
    en  = e;
    req = q;
    @(posedge clk);
    model_step(r, e, q);
    #1;
    check_model();
  endtask

  initial begin
    logic [7:0] rq;
    int         eg;

    rst = 1'b1;
    en  = 1'b0;
    req = 8'd0;
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_ten[i]   = 0;
      m_last[i]  = 7;
    end

    // Idle after reset with no requests
    cyc(1'b1, 1'b1, 8'h00);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check("idle_gnt", int'(gnt_w[0]), 0);
      check("idle_vx", int'(vx_w[0]), 0);
      check("idle_seg", int'(seg_w[0]), 7'h7F);
    end

    // Table: MAX_HOLD=1 instance walking, reset mid-walk, en gating
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 7'b1111111};
    tbl[1]  = '{1'b0, 1'b1, 8'hFF, 8'h01, 3'd0, 7'b1000000};
    tbl[2]  = '{1'b0, 1'b1, 8'hFF, 8'h02, 3'd1, 7'b1111001};
    tbl[3]  = '{1'b0, 1'b1, 8'hFF, 8'h04, 3'd2, 7'b0100100};
    tbl[4]  = '{1'b0, 1'b1, 8'hFF, 8'h08, 3'd3, 7'b0110000};
    tbl[5]  = '{1'b0, 1'b1, 8'hFF, 8'h10, 3'd4, 7'b0011001};
    tbl[6]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 7'b1111111};
    tbl[7]  = '{1'b0, 1'b1, 8'hFF, 8'h01, 3'd0, 7'b1000000};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 7'b1111111};
    tbl[9]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 3'd0, 7'b1111111};
    tbl[10] = '{1'b0, 1'b1, 8'h06, 8'h02, 3'd1, 7'b1111001};
    tbl[11] = '{1'b0, 1'b1, 8'h06, 8'h04, 3'd2, 7'b0100100};
    tbl[12] = '{1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 7'b0100100};
    for (int v = 0; v < 13; v++) begin
      cyc(tbl[v].r, tbl[v].e, tbl[v].q);
      check($sformatf("tbl%0d_gnt", v), int'(gnt_w[2]), int'(tbl[v].g));
      check($sformatf("tbl%0d_id", v), int'(id_w[2]), int'(tbl[v].id));
      check($sformatf("tbl%0d_seg", v), int'(seg_w[2]), int'(tbl[v].s));
      check($sformatf("tbl%0d_vx", v), int'(vx_w[2]), int'(tbl[v].g != 8'd0));
    end

    // Two requesters alternate every 8 cycles at MAX_HOLD=8
    cyc(1'b1, 1'b1, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      cyc(1'b0, 1'b1, 8'h81);
      eg = (k <= 8 || k == 17) ? 8'h01 : 8'h80;
      check($sformatf("alt%0d_gnt", k), int'(gnt_w[0]), eg);
      check($sformatf("alt%0d_seg", k), int'(seg_w[0]),
            (eg == 8'h01) ? 7'b1000000 : 7'b1111000);
    end

    // Owner 2 drops; requester 5 takes over on the same edge
    cyc(1'b1, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h04);
    check("ho_first", int'(gnt_w[0]), 8'h04);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 8'h24);
      check("ho_hold", int'(gnt_w[0]), 8'h04);
    end
    cyc(1'b0, 1'b1, 8'h20);
    check("ho_gnt", int'(gnt_w[0]), 8'h20);
    check("ho_id", int'(id_w[0]), 5);
    check("ho_vx", int'(vx_w[0]), 1);
    check("ho_seg", int'(seg_w[0]), 7'b0010010);

    // Sole requester at MAX_HOLD=4 never loses the grant
    cyc(1'b1, 1'b1, 8'h00);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b1, 8'h08);
      check("sole_gnt", int'(gnt_w[1]), 8'h08);
      check("sole_vx", int'(vx_w[1]), 1);
    end

    // en dropped mid-tenure, then resumption after the last owner
    cyc(1'b1, 1'b1, 8'h00);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 8'hFF);
    cyc(1'b0, 1'b0, 8'hFF);
    check("en_off_gnt", int'(gnt_w[0]), 0);
    check("en_off_vx", int'(vx_w[0]), 0);
    cyc(1'b0, 1'b1, 8'hFF);
    check("en_on_gnt", int'(gnt_w[0]), 8'h02);

    // Randomized traffic against the reference model
    rq = 8'd0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) != 0), rq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
